// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - shared encodings and constants for the gate self-test engine
// Contents: gate_sel function codes, FSM state type, vector count.
package gate_pkg;

   localparam logic [2:0] GATE_AND  = 3'd0;
   localparam logic [2:0] GATE_OR   = 3'd1;
   localparam logic [2:0] GATE_NAND = 3'd2;
   localparam logic [2:0] GATE_NOR  = 3'd3;
   localparam logic [2:0] GATE_XOR  = 3'd4;
   localparam logic [2:0] GATE_XNOR = 3'd5;
   localparam logic [2:0] GATE_NOT  = 3'd6;
   localparam logic [2:0] GATE_BUF  = 3'd7;

   // One vector per {A,B} combination of a two-input gate
   localparam int VEC_CNT = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_DONE
   } state_t;

endpackage

// File: rtl/gate_model.sv
// rtl/gate_model.sv - combinational golden model of the two-input gate library
// Ports: sel (gate function code), A, B (gate inputs), Y (expected gate output).
module gate_model
   import gate_pkg::*;
(
   input  logic [2:0] sel,
   input  logic       A,
   input  logic       B,
   output logic       Y
);

   always_comb begin
      Y = 1'b0;
      case (sel)
         GATE_AND:  Y = A & B;
         GATE_OR:   Y = A | B;
         GATE_NAND: Y = ~(A & B);
         GATE_NOR:  Y = ~(A | B);
         GATE_XOR:  Y = A ^ B;
         GATE_XNOR: Y = ~(A ^ B);
         GATE_NOT:  Y = ~A;
         GATE_BUF:  Y = A;
         default:   Y = 1'b0;
      endcase
   end

endmodule

// File: rtl/gate_bist.sv
// rtl/gate_bist.sv - built-in self-test engine for a two-input logic gate
// Ports: clk, rst (async active-high); start, gate_sel (run request, function);
// y_in (gate output); a_out, b_out (gate drive); busy, done, pass, err_cnt, fail_vec (status).
module gate_bist
   import gate_pkg::*;
#(
   parameter int SETTLE = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [2:0] gate_sel,
   input  logic       y_in,
   output logic       a_out,
   output logic       b_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_cnt,
   output logic [3:0] fail_vec
);

   localparam logic [3:0] SETTLE_C = 4'(SETTLE);
   localparam logic [1:0] LAST_IDX = 2'(VEC_CNT - 1);

   state_t     state;
   logic [2:0] sel_q;
   logic [1:0] idx;
   logic [3:0] hold;
   logic       y_exp;
   logic       mismatch;
   logic [2:0] err_next;

   // The golden model sees the registered drive, so it always matches the vector held on the gate
   gate_model u_model (
      .sel (sel_q),
      .A   (a_out),
      .B   (b_out),
      .Y   (y_exp)
   );

   assign mismatch = (y_in != y_exp);
   assign err_next = err_cnt + {2'b00, mismatch};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         sel_q    <= 3'd0;
         idx      <= 2'd0;
         hold     <= 4'd0;
         a_out    <= 1'b0;
         b_out    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         err_cnt  <= 3'd0;
         fail_vec <= 4'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  sel_q    <= gate_sel;
                  err_cnt  <= 3'd0;
                  fail_vec <= 4'd0;
                  pass     <= 1'b0;
                  idx      <= 2'd0;
                  hold     <= 4'd0;
                  a_out    <= 1'b0;
                  b_out    <= 1'b0;
                  busy     <= 1'b1;
                  state    <= ST_DRIVE;
               end
            end

            ST_DRIVE: begin
               if (hold == SETTLE_C) begin
                  // Sample edge for the current vector
                  err_cnt <= err_next;
                  if (mismatch) begin
                     fail_vec[idx] <= 1'b1;
                  end
                  if (idx == LAST_IDX) begin
                     a_out <= 1'b0;
                     b_out <= 1'b0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (err_next == 3'd0);
                     state <= ST_DONE;
                  end else begin
                     idx            <= idx + 2'd1;
                     hold           <= 4'd0;
                     {a_out, b_out} <= idx + 2'd1;
                  end
               end else begin
                  hold <= hold + 4'd1;
               end
            end

            ST_DONE: begin
               // start is deliberately ignored here; it is honoured from the next (IDLE) cycle
               done  <= 1'b0;
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gate_bist.sv
// tb/tb_gate_bist.sv - self-checking bench for gate_bist with SETTLE=0 and SETTLE=1 instances
module tb_gate_bist;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_s [2];
   logic [2:0] sel_s   [2];
   logic       y_s     [2];
   logic       a_o     [2];
   logic       b_o     [2];
   logic       busy_o  [2];
   logic       done_o  [2];
   logic       pass_o  [2];
   logic [2:0] err_o   [2];
   logic [3:0] fail_o  [2];
   logic [3:0] tt      [2];

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   gate_bist #(.SETTLE(0)) dut0 (
      .clk(clk), .rst(rst), .start(start_s[0]), .gate_sel(sel_s[0]), .y_in(y_s[0]),
      .a_out(a_o[0]), .b_out(b_o[0]), .busy(busy_o[0]), .done(done_o[0]),
      .pass(pass_o[0]), .err_cnt(err_o[0]), .fail_vec(fail_o[0])
   );

   gate_bist #(.SETTLE(1)) dut1 (
      .clk(clk), .rst(rst), .start(start_s[1]), .gate_sel(sel_s[1]), .y_in(y_s[1]),
      .a_out(a_o[1]), .b_out(b_o[1]), .busy(busy_o[1]), .done(done_o[1]),
      .pass(pass_o[1]), .err_cnt(err_o[1]), .fail_vec(fail_o[1])
   );

   // Emulated gate under test: truth table indexed by {A,B}
   assign y_s[0] = tt[0][{a_o[0], b_o[0]}];
   assign y_s[1] = tt[1][{a_o[1], b_o[1]}];

   // Truth table of each library function, bit i = output for {A,B}=i
   function automatic logic [3:0] truth(input logic [2:0] s);
      case (s)
         3'd0:    return 4'b1000;
         3'd1:    return 4'b1110;
         3'd2:    return 4'b0111;
         3'd3:    return 4'b0001;
         3'd4:    return 4'b0110;
         3'd5:    return 4'b1001;
         3'd6:    return 4'b0011;
         default: return 4'b1100;
      endcase
   endfunction

   task automatic chk(input string nm, input int d, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, d, act, exp, $time);
      end
   endtask

   // Behavioural model: a run is a timeline of 4(S+1) drive cycles then one done cycle
   bit         m_act  [2] = '{1'b0, 1'b0};
   int         m_t    [2] = '{0, 0};
   logic [3:0] m_mask [2] = '{4'd0, 4'd0};
   logic [3:0] m_lfail[2] = '{4'd0, 4'd0};
   logic       m_lpass[2] = '{1'b0, 1'b0};

   always @(posedge clk or posedge rst) begin
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            m_act[d]   = 1'b0;
            m_t[d]     = 0;
            m_lfail[d] = 4'd0;
            m_lpass[d] = 1'b0;
         end else if (m_act[d]) begin
            m_t[d]++;
            if (m_t[d] > 4 * (d + 1)) m_act[d] = 1'b0;
         end else if (start_s[d]) begin
            m_act[d]  = 1'b1;
            m_t[d]    = 0;
            m_mask[d] = truth(sel_s[d]) ^ tt[d];
         end
         if (m_act[d] && m_t[d] == 4 * (d + 1)) begin
            m_lfail[d] = m_mask[d];
            m_lpass[d] = (m_mask[d] == 4'd0);
         end
      end
   end

   logic       e_busy, e_done, e_pass;
   logic [1:0] e_vec;
   logic [3:0] e_fail;

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (m_act[d] && m_t[d] < 4 * (d + 1)) begin
            e_busy = 1'b1;
            e_done = 1'b0;
            e_pass = 1'b0;
            e_vec  = 2'(m_t[d] / (d + 1));
            e_fail = 4'd0;
            for (int i = 0; i < 4; i++)
               if ((i + 1) * (d + 1) <= m_t[d]) e_fail[i] = m_mask[d][i];
         end else if (m_act[d]) begin
            e_busy = 1'b0;
            e_done = 1'b1;
            e_vec  = 2'd0;
            e_fail = m_mask[d];
            e_pass = (m_mask[d] == 4'd0);
         end else begin
            e_busy = 1'b0;
            e_done = 1'b0;
            e_vec  = 2'd0;
            e_fail = m_lfail[d];
            e_pass = m_lpass[d];
         end
         chk("busy",     d, int'(busy_o[d]), int'(e_busy));
         chk("done",     d, int'(done_o[d]), int'(e_done));
         chk("a_out",    d, int'(a_o[d]),    int'(e_vec[1]));
         chk("b_out",    d, int'(b_o[d]),    int'(e_vec[0]));
         chk("pass",     d, int'(pass_o[d]), int'(e_pass));
         chk("fail_vec", d, int'(fail_o[d]), int'(e_fail));
         chk("err_cnt",  d, int'(err_o[d]),  $countones(e_fail));
      end
   end

   logic [1:0] trace [16];

   // Launch a run; optionally re-pulse start (with a new sel) or assert rst at cycle k.
   // lat = cycles from start to done, -1 when aborted by reset.
   task automatic run(input int d, input logic [2:0] s, input int rp_at, input logic [2:0] rp_sel,
                      input int rst_at, output int lat);
      int k;
      @(negedge clk);
      #1;
      start_s[d] = 1'b1;
      sel_s[d]   = s;
      lat = -2;
      k   = 0;
      while (lat == -2 && k < 60) begin
         k++;
         @(negedge clk);
         if (k <= 16) trace[k-1] = {a_o[d], b_o[d]};
         if (done_o[d]) begin
            lat = k - 1;
         end else begin
            #1;
            if (k == 1) start_s[d] = 1'b0;
            if (rp_at != 0 && k == rp_at) begin
               start_s[d] = 1'b1;
               sel_s[d]   = rp_sel;
            end
            if (rp_at != 0 && k == rp_at + 1) start_s[d] = 1'b0;
            if (rst_at != 0 && k == rst_at) begin
               rst = 1'b1;
               #1;
               chk("rst_busy",  d, int'(busy_o[d]), 0);
               chk("rst_ab",    d, int'({a_o[d], b_o[d]}), 0);
               chk("rst_done",  d, int'(done_o[d]), 0);
               chk("rst_err",   d, int'(err_o[d]), 0);
               chk("rst_fail",  d, int'(fail_o[d]), 0);
               chk("rst_pass",  d, int'(pass_o[d]), 0);
               @(negedge clk);
               #1;
               rst = 1'b0;
               lat = -1;
            end
         end
      end
      start_s[d] = 1'b0;
      if (lat == -2) chk("timeout", d, k, 0);
   endtask

   int         lat;
   int         extra_done;
   logic [1:0] exp_tr [8];

   initial begin
      start_s = '{1'b0, 1'b0};
      sel_s   = '{3'd0, 3'd0};
      tt[0]   = 4'b0011;
      tt[1]   = 4'b1001;
      exp_tr  = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
      repeat (2) @(negedge clk);
      #1;
      rst = 1'b0;
      chk("reset_busy", 1, int'(busy_o[1]), 0);
      chk("reset_pass", 1, int'(pass_o[1]), 0);
      chk("reset_err",  1, int'(err_o[1]),  0);
      chk("reset_fail", 1, int'(fail_o[1]), 0);

      // XNOR gate checked as XNOR
      run(1, 3'd5, 0, 3'd0, 0, lat);
      chk("t1_latency", 1, lat, 8);
      chk("t1_pass", 1, int'(pass_o[1]), 1);
      chk("t1_err",  1, int'(err_o[1]),  0);
      chk("t1_fail", 1, int'(fail_o[1]), 0);
      for (int i = 0; i < 8; i++) chk("t1_vector", 1, int'(trace[i]), int'(exp_tr[i]));

      // XNOR gate checked as XOR
      run(1, 3'd4, 0, 3'd0, 0, lat);
      chk("t2_latency", 1, lat, 8);
      chk("t2_pass", 1, int'(pass_o[1]), 0);
      chk("t2_err",  1, int'(err_o[1]),  4);
      chk("t2_fail", 1, int'(fail_o[1]), 15);

      // Stuck-at-0 gate checked as AND
      tt[1] = 4'b0000;
      run(1, 3'd0, 0, 3'd0, 0, lat);
      chk("t3_pass", 1, int'(pass_o[1]), 0);
      chk("t3_err",  1, int'(err_o[1]),  1);
      chk("t3_fail", 1, int'(fail_o[1]), 8);

      // Re-pulsed start and sel change mid-run
      tt[1] = 4'b1001;
      run(1, 3'd5, 3, 3'd4, 0, lat);
      chk("t4_latency", 1, lat, 8);
      chk("t4_pass", 1, int'(pass_o[1]), 1);
      chk("t4_fail", 1, int'(fail_o[1]), 0);
      extra_done = 0;
      repeat (12) begin
         @(negedge clk);
         if (done_o[1]) extra_done++;
      end
      chk("t4_single_done", 1, extra_done, 0);

      // Reset mid-run, then a clean run; then a back-to-back run
      run(1, 3'd5, 0, 3'd0, 5, lat);
      chk("t5_aborted", 1, lat, -1);
      run(1, 3'd5, 0, 3'd0, 0, lat);
      chk("t5_latency", 1, lat, 8);
      chk("t5_pass", 1, int'(pass_o[1]), 1);
      run(1, 3'd4, 0, 3'd0, 0, lat);
      chk("t5_b2b_latency", 1, lat, 8);
      chk("t5_b2b_err", 1, int'(err_o[1]), 4);

      // SETTLE=0, NOT-A gate
      run(0, 3'd6, 0, 3'd0, 0, lat);
      chk("t6_latency", 0, lat, 4);
      chk("t6_pass", 0, int'(pass_o[0]), 1);
      chk("t6_fail", 0, int'(fail_o[0]), 0);
      for (int i = 0; i < 4; i++) chk("t6_vector", 0, int'(trace[i]), i);

      // SETTLE=0, NOT-A gate checked as BUF
      run(0, 3'd7, 0, 3'd0, 0, lat);
      chk("t7_err",  0, int'(err_o[0]),  4);
      chk("t7_pass", 0, int'(pass_o[0]), 0);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/gate_bist.md
# gate_bist

Built-in self-test engine for the two-input logic-gate library. It drives all four input combinations to a gate under test, samples the gate's output after a programmable settle time, and compares each sample against a golden model of the selected gate function. It reports a pass/fail flag, an error count and a per-vector failure mask. It sits beside any `A`/`B`→`Y` gate instance and stands in for a simulation bench, so the checks also run on hardware.

## Interface

Parameters:
- `SETTLE`, default 1: extra cycles each vector is held before `y_in` is sampled; legal range 0–15.

Ports (name, direction, width, meaning):
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a run; honoured only in IDLE.
- `gate_sel`  in  3  function of the gate under test; latched on an accepted `start`.
- `y_in`  in  1  output of the gate under test.
- `a_out`  out  1  drives gate input `A`; registered.
- `b_out`  out  1  drives gate input `B`; registered.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  one-cycle pulse when a run completes.
- `pass`  out  1  high when the last run had zero mismatches; held until the next accepted `start`.
- `err_cnt`  out  3  mismatch count of the last run (0–4).
- `fail_vec`  out  4  bit i set when vector i ({A,B}=i) mismatched.

## Operation

**`gate_sel` encoding:**
- 0 AND
- 1 OR
- 2 NAND
- 3 NOR
- 4 XOR
- 5 XNOR
- 6 NOT A (`B` ignored)
- 7 BUF A (`B` ignored)

**States:**
- IDLE: `a_out`/`b_out` = 0, `busy` = 0.
  - `start`=1 → latch `gate_sel`; clear `err_cnt`, `fail_vec` and `pass`; set vector index to 0; go to DRIVE.
- DRIVE: `{a_out,b_out}` = index, `busy` = 1, and a hold counter counts 0..SETTLE.
  - When the counter equals SETTLE, on that edge: sample `y_in` and compare it against the golden model of the latched `gate_sel`.
  - On a mismatch: set `fail_vec[index]` and increment `err_cnt`.
  - If index = 3 → go to DONE; otherwise index+1 and reset the hold counter.
- DONE: for one cycle, `done` = 1, `busy` = 0, `pass` = (`err_cnt` == 0), inputs return to 0; then go to IDLE.

**Rules and boundary conditions:**
- `start` while busy or in DONE is ignored; no queuing.
- `gate_sel` changes during a run have no effect.
- The index counts 0→3 with no wrap-around.
- `err_cnt` saturation is unnecessary: its maximum is 4.
- `y_in` is treated as synchronous to `clk`. No synchroniser; the settle time covers gate delay.
- `rst` asserted mid-run aborts immediately: state IDLE, all outputs 0, and results are lost.
- Reset values: `a_out`=0, `b_out`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `fail_vec`=0.

## Timing

- `start` is sampled at edge E0. `busy` and vector 0 are visible after E0.
- Each vector is held for SETTLE+1 cycles.
- The vector-i sample is taken at edge E0 + (i+1)(SETTLE+1).
- `done` is high during the cycle after the final sample, i.e. from edge E0 + 4(SETTLE+1) to the following edge.
- Total latency from `start` to `done` = 4(SETTLE+1) cycles. With SETTLE=1 this is 8.
- `pass`, `err_cnt` and `fail_vec` are final when `done` rises and stay stable until the next accepted `start`.
- A back-to-back `start` is accepted in the cycle after DONE (first IDLE cycle).

## Structure

- Shared package `gate_pkg`:
  - `gate_sel` encoding constants (`GATE_AND` … `GATE_BUF`).
  - FSM state typedef (IDLE, DRIVE, DONE).
  - Vector count constant (4).
- Sub-module `gate_model`: purely combinational golden model with inputs `sel`, `A`, `B` and output `Y`. It is reused by benches as the reference checker.
- Top level holds the FSM, hold counter, index counter and result registers.

## Test plan

- XNOR DUT, `gate_sel`=5, SETTLE=1, single `start` pulse:
  - `{a_out,b_out}` steps through 00, 01, 10, 11, two cycles each.
  - `done` arrives 8 cycles after `start`.
  - `pass`=1, `err_cnt`=0, `fail_vec`=0000.
- XNOR DUT with `gate_sel`=4 (XOR expected): every vector mismatches, giving `err_cnt`=4, `fail_vec`=1111, `pass`=0.
- `y_in` stuck at 0, `gate_sel`=0 (AND): only vector 3 fails, giving `fail_vec`=1000, `err_cnt`=1, `pass`=0.
- `start` re-pulsed at cycle 3 of a run, and `gate_sel` changed mid-run: the run is unaffected, with a single `done` at cycle 8 and the original function checked.
- `rst` raised at cycle 5 of a run: all outputs are 0 immediately (asynchronously) and there is no `done`. A new `start` after release completes normally.
- SETTLE=0, NOT-A DUT, `gate_sel`=6: each vector is held 1 cycle, `done` arrives 4 cycles after `start`, and `pass`=1.
